hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline-side hazard inputs and the enable/clear/MDU status outputs.
interface hazard_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       branch_d;
    logic       pcsrc_d;
    logic [4:0] rt_e;
    logic [4:0] writereg_e;
    logic       memtoreg_e;
    logic       regwrite_e;
    logic [4:0] writereg_m;
    logic       memtoreg_m;
    logic [1:0] mdu_op_e;
    logic       en_f;
    logic       en_d;
    logic       en_e;
    logic       en_m;
    logic       clr_d;
    logic       clr_e;
    logic       clr_m;
    logic       mdu_busy;
    logic       mdu_done;

    modport master (
        output rs_d, rt_d, branch_d, pcsrc_d, rt_e, writereg_e, memtoreg_e, regwrite_e,
               writereg_m, memtoreg_m, mdu_op_e,
        input  en_f, en_d, en_e, en_m, clr_d, clr_e, clr_m, mdu_busy, mdu_done
    );

    modport slave (
        input  rs_d, rt_d, branch_d, pcsrc_d, rt_e, writereg_e, memtoreg_e, regwrite_e,
               writereg_m, memtoreg_m, mdu_op_e,
        output en_f, en_d, en_e, en_m, clr_d, clr_e, clr_m, mdu_busy, mdu_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch stalls, taken-branch flush, and a multi-cycle
// MDU stall sequencer that holds F/D/E while injecting bubbles into M.
module hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input logic      clk,
    input logic      reset,
    hazard_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdu_start;
    logic             mdu_stall;
    logic             load_use;
    logic             branch_haz;
    logic             e_fwd_hit;
    logic             m_load_hit;

    assign mdu_start = (bus.mdu_op_e == 2'b01) || (bus.mdu_op_e == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall spans the IDLE start cycle plus LAT-1 BUSY cycles, hence the LAT-2 preload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (mdu_start) begin
                    state_d = StBusy;
                    cnt_d   = (bus.mdu_op_e == 2'b01) ? CNT_W'(MUL_LAT - 2) : CNT_W'(DIV_LAT - 2);
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mdu_stall = !reset && (((state_q == StIdle) && mdu_start) || (state_q == StBusy));

    assign load_use = bus.memtoreg_e && (bus.rt_e != 5'd0) &&
                      ((bus.rt_e == bus.rs_d) || (bus.rt_e == bus.rt_d));

    assign e_fwd_hit  = bus.regwrite_e && (bus.writereg_e != 5'd0) &&
                        ((bus.writereg_e == bus.rs_d) || (bus.writereg_e == bus.rt_d));
    assign m_load_hit = bus.memtoreg_m && (bus.writereg_m != 5'd0) &&
                        ((bus.writereg_m == bus.rs_d) || (bus.writereg_m == bus.rt_d));
    assign branch_haz = bus.branch_d && (e_fwd_hit || m_load_hit);

    always_comb begin
        bus.en_f     = 1'b1;
        bus.en_d     = 1'b1;
        bus.en_e     = 1'b1;
        bus.en_m     = 1'b1;
        bus.clr_d    = 1'b0;
        bus.clr_e    = 1'b0;
        bus.clr_m    = 1'b0;
        bus.mdu_busy = 1'b0;
        bus.mdu_done = 1'b0;
        if (!reset) begin
            if (mdu_stall) begin
                // Hold F/D/E (MDU op stays in E) and push bubbles into M.
                bus.en_f     = 1'b0;
                bus.en_d     = 1'b0;
                bus.en_e     = 1'b0;
                bus.clr_m    = 1'b1;
                bus.mdu_busy = 1'b1;
            end else begin
                bus.mdu_done = (state_q == StDone);
                if (load_use || branch_haz) begin
                    bus.en_f  = 1'b0;
                    bus.en_d  = 1'b0;
                    bus.clr_e = 1'b1;
                end else if (bus.pcsrc_d) begin
                    bus.clr_d = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-count reference model of the stall rules.
module tb_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // Reference model: stall cycles still owed after the current one, and a pending done cycle.
    int   mdl_left;
    bit   mdl_done;
    logic [8:0] last_out;

    hazard_if hif ();

    hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {en_f, en_d, en_e, en_m, clr_d, clr_e, clr_m, mdu_busy, mdu_done}
    function automatic logic [8:0] dut_vec();
        return {hif.en_f, hif.en_d, hif.en_e, hif.en_m, hif.clr_d, hif.clr_e, hif.clr_m,
                hif.mdu_busy, hif.mdu_done};
    endfunction

    function automatic logic [8:0] model_out();
        logic [8:0] e;
        bit lu, br, stall, ehit, mhit;
        e = 9'b111100000;
        if (reset) return e;
        stall = (mdl_left > 0) || (!mdl_done && (hif.mdu_op_e == 2'd1 || hif.mdu_op_e == 2'd2));
        if (stall) return 9'b000100110;
        lu   = hif.memtoreg_e && hif.rt_e != 0 && (hif.rt_e == hif.rs_d || hif.rt_e == hif.rt_d);
        ehit = hif.regwrite_e && hif.writereg_e != 0 &&
               (hif.writereg_e == hif.rs_d || hif.writereg_e == hif.rt_d);
        mhit = hif.memtoreg_m && hif.writereg_m != 0 &&
               (hif.writereg_m == hif.rs_d || hif.writereg_m == hif.rt_d);
        br   = hif.branch_d && (ehit || mhit);
        e[0] = mdl_done;
        if (lu || br) begin
            e[8] = 1'b0;
            e[7] = 1'b0;
            e[3] = 1'b1;
        end else if (hif.pcsrc_d) begin
            e[4] = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_update();
        if (reset) begin
            mdl_left = 0;
            mdl_done = 0;
        end else if (mdl_left > 0) begin
            mdl_left--;
            if (mdl_left == 0) mdl_done = 1;
        end else if (mdl_done) begin
            mdl_done = 0;
        end else if (hif.mdu_op_e == 2'd1) begin
            mdl_left = MUL_LAT - 1;
        end else if (hif.mdu_op_e == 2'd2) begin
            mdl_left = DIV_LAT - 1;
        end
    endfunction

    task automatic step(input string tag);
        logic [8:0] got;
        @(negedge clk);
        got = dut_vec();
        last_out = got;
        check_eq(tag, 32'(got), 32'(model_out()));
        check_eq({tag, "_clr_vs_en"},
                 32'((hif.clr_d & ~hif.en_d) | (hif.clr_e & ~hif.en_e) | (hif.clr_m & ~hif.en_m)),
                 32'd0);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        hif.rs_d = 5'd0; hif.rt_d = 5'd0; hif.branch_d = 1'b0; hif.pcsrc_d = 1'b0;
        hif.rt_e = 5'd0; hif.writereg_e = 5'd0; hif.memtoreg_e = 1'b0; hif.regwrite_e = 1'b0;
        hif.writereg_m = 5'd0; hif.memtoreg_m = 1'b0; hif.mdu_op_e = 2'd0;
    endtask

    task automatic rand_inputs();
        hif.rs_d       = 5'($urandom_range(0, 7));
        hif.rt_d       = 5'($urandom_range(0, 7));
        hif.branch_d   = 1'($urandom_range(0, 1));
        hif.pcsrc_d    = 1'($urandom_range(0, 1));
        hif.rt_e       = 5'($urandom_range(0, 7));
        hif.writereg_e = 5'($urandom_range(0, 7));
        hif.memtoreg_e = 1'($urandom_range(0, 1));
        hif.regwrite_e = 1'($urandom_range(0, 1));
        hif.writereg_m = 5'($urandom_range(0, 7));
        hif.memtoreg_m = 1'($urandom_range(0, 1));
        hif.mdu_op_e   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    endtask

    // Runs an MDU op to completion; reports busy cycles, clr_m and clr_e counts while busy.
    task automatic run_mdu(input string tag, output int busy_n, output int clrm_n,
                           output int clre_n, output bit done_seen, output bit en_e_done);
        busy_n = 0; clrm_n = 0; clre_n = 0; done_seen = 0; en_e_done = 0;
        for (int i = 0; i < 100; i++) begin
            step(tag);
            if (last_out[1]) begin
                busy_n++;
                if (last_out[2]) clrm_n++;
                if (last_out[3]) clre_n++;
            end
            if (last_out[0]) begin
                done_seen = 1;
                en_e_done = last_out[6];
                break;
            end
        end
    endtask

    initial begin
        int  busy_n, clrm_n, clre_n, done_n;
        bit  done_seen, en_e_done;
        n_checks = 0;
        n_fail   = 0;
        mdl_left = 0;
        mdl_done = 0;
        last_out = '0;

        // Reset forces defaults even with active hazard/MDU inputs.
        reset = 1'b1;
        rand_inputs();
        hif.mdu_op_e = 2'd1;
        hif.memtoreg_e = 1'b1; hif.rt_e = 5'd3; hif.rs_d = 5'd3;
        step("reset_defaults");
        step("reset_defaults2");
        reset = 1'b0;
        idle_inputs();
        step("post_reset_idle");

        // Load-use, then the same with rt_e=0.
        hif.memtoreg_e = 1'b1; hif.rt_e = 5'd5; hif.rs_d = 5'd5;
        step("load_use");
        hif.rt_e = 5'd0;
        step("load_use_r0");
        idle_inputs();

        // Branch on E result with taken flag: stall wins, then flush.
        hif.branch_d = 1'b1; hif.regwrite_e = 1'b1; hif.writereg_e = 5'd7; hif.rt_d = 5'd7;
        hif.pcsrc_d = 1'b1;
        step("branch_stall");
        check_eq("branch_stall_clr_d", 32'(last_out[4]), 32'd0);
        hif.regwrite_e = 1'b0;
        step("branch_flush");
        check_eq("branch_flush_clr_d", 32'(last_out[4]), 32'd1);
        idle_inputs();

        // Multiply.
        hif.mdu_op_e = 2'd1;
        run_mdu("mul", busy_n, clrm_n, clre_n, done_seen, en_e_done);
        check_eq("mul_busy_cycles", 32'(busy_n), 32'(MUL_LAT));
        check_eq("mul_done_seen", 32'(done_seen), 32'd1);
        check_eq("mul_done_en_e", 32'(en_e_done), 32'd1);
        idle_inputs();
        step("mul_after");

        // Divide with a simultaneous load-use hazard.
        hif.mdu_op_e = 2'd2;
        hif.memtoreg_e = 1'b1; hif.rt_e = 5'd3; hif.rs_d = 5'd3;
        run_mdu("div", busy_n, clrm_n, clre_n, done_seen, en_e_done);
        check_eq("div_busy_cycles", 32'(busy_n), 32'(DIV_LAT));
        check_eq("div_clr_m_cycles", 32'(clrm_n), 32'(DIV_LAT));
        check_eq("div_clr_e_in_stall", 32'(clre_n), 32'd0);
        check_eq("div_done_seen", 32'(done_seen), 32'd1);
        idle_inputs();
        step("div_after");

        // Reset in BUSY cycle 10 of a divide.
        hif.mdu_op_e = 2'd2;
        for (int i = 0; i < 11; i++) step("div_abort_run");
        reset = 1'b1;
        hif.mdu_op_e = 2'd0;
        step("div_abort_reset");
        reset = 1'b0;
        step("div_abort_after");
        check_eq("div_abort_busy", 32'(last_out[1]), 32'd0);
        check_eq("div_abort_enables", 32'(last_out[8:5]), 32'hf);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            step("div_abort_quiet");
            if (last_out[0]) done_n++;
        end
        check_eq("div_abort_no_done", 32'(done_n), 32'd0);

        // Reserved op code.
        hif.mdu_op_e = 2'd3;
        busy_n = 0;
        for (int i = 0; i < 5; i++) begin
            step("op_reserved");
            if (last_out[1]) busy_n++;
        end
        check_eq("op_reserved_busy", 32'(busy_n), 32'd0);
        idle_inputs();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 199) == 0);
            step("random");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
